operand_fetch_stage: RTL and testbench

- Pipeline stage directly upstream of the 64x32 register file (2 read ports, 1 write port).
- Accepts decoded instructions (two source indices, one destination), drives the register-file read addresses, and captures the 64-bit operands into an output register.
- Keeps a 32-entry pending-write scoreboard, cleared by the writeback port, and stalls on RAW/WAW hazards.
- Register file contract: combinational reads; write takes effect on the rising clk edge when wena=1.

---
 rtl/operand_fetch_pkg.sv | 18 +
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/operand_fetch_stage.sv | 155 +++++++++++++++
 tb/tb_operand_fetch_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage.
// Holds the default widths of the datapath and register index, the
// register count, and the {dst, dst_wen} descriptor type used by
// downstream consumers of the stage's destination output.
package operand_fetch_pkg;

    localparam int OF_DATA_WIDTH = 64;
    localparam int OF_ADDR_WIDTH = 5;
    localparam int OF_NUM_REGS   = 2 ** OF_ADDR_WIDTH;
    localparam int OF_CNT_WIDTH  = 16;

    // Destination descriptor carried alongside captured operands.
    typedef struct packed {
        logic [OF_ADDR_WIDTH-1:0] dst;
        logic                     dst_wen;
    } dst_desc_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for the register file.
// One bit per register: set when an instruction that writes the register
// is accepted, cleared when writeback retires the write. When the same
// index is set and cleared in one cycle the set wins, because the new
// write is still outstanding after the old one retires.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset (clears all bits)
//   set_en, set_addr     mark a register as having a pending write
//   clr_en, clr_addr     retire the pending write of a register
//   src0, src1, dst      lookup indices
//   pend_src0/1, pend_dst  pending bit of the corresponding lookup index
module regfile_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = OF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] src0,
    input  logic [ADDR_WIDTH-1:0] src1,
    input  logic [ADDR_WIDTH-1:0] dst,
    output logic                  pend_src0,
    output logic                  pend_src1,
    output logic                  pend_dst
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            // Set has priority over clear; clearing a zero bit changes nothing.
            assign pend_d[gi] = (set_en && set_addr == ADDR_WIDTH'(gi)) ? 1'b1 :
                                (clr_en && clr_addr == ADDR_WIDTH'(gi)) ? 1'b0 :
                                pend_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_src0 = pend_q[src0];
    assign pend_src1 = pend_q[src1];
    assign pend_dst  = pend_q[dst];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage sitting in front of a register file with two
// combinational read ports and one clocked write port.
// Drives the read addresses straight from the incoming source indices,
// captures both operands plus the destination descriptor into an output
// register with a valid/ready handshake, and stalls on RAW/WAW hazards
// tracked by a pending-write scoreboard.
//
// Configuration macro: OPERAND_BYPASS_EN
//   defined   : a source whose pending write is being retired by writeback
//               this cycle is not a hazard; its operand takes wb_wdata.
//   undefined : such a source stalls one more cycle and reads the regfile.
//   WAW hazards are never bypassed in either build.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          upstream handshake
//   in_src0/1, in_dst, in_dst_wen  decoded instruction fields
//   rf_r0addr/rf_r1addr        register file read addresses
//   rf_r0data/rf_r1data        register file read data
//   wb_wena/wb_waddr/wb_wdata  copy of the register file write port
//   out_valid/out_ready        downstream handshake
//   out_op0/1, out_dst, out_dst_wen  captured operands and destination
//   stall_count                saturating count of cycles with in_valid & !in_ready
module operand_fetch_stage
    import operand_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = OF_DATA_WIDTH,
    parameter int ADDR_WIDTH = OF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = OF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_src0,
    input  logic [ADDR_WIDTH-1:0] in_src1,
    input  logic [ADDR_WIDTH-1:0] in_dst,
    input  logic                  in_dst_wen,
    output logic [ADDR_WIDTH-1:0] rf_r0addr,
    output logic [ADDR_WIDTH-1:0] rf_r1addr,
    input  logic [DATA_WIDTH-1:0] rf_r0data,
    input  logic [DATA_WIDTH-1:0] rf_r1data,
    input  logic                  wb_wena,
    input  logic [ADDR_WIDTH-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op0,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [ADDR_WIDTH-1:0] out_dst,
    output logic                  out_dst_wen,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    logic                  pend_src0;
    logic                  pend_src1;
    logic                  pend_dst;
    logic                  byp0;
    logic                  byp1;
    logic                  hazard;
    logic                  ready;
    logic                  accept;

    logic                  out_valid_q,   out_valid_d;
    logic [DATA_WIDTH-1:0] out_op0_q,     out_op0_d;
    logic [DATA_WIDTH-1:0] out_op1_q,     out_op1_d;
    logic [ADDR_WIDTH-1:0] out_dst_q,     out_dst_d;
    logic                  out_dst_wen_q, out_dst_wen_d;
    logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (accept & in_dst_wen),
        .set_addr  (in_dst),
        .clr_en    (wb_wena),
        .clr_addr  (wb_waddr),
        .src0      (in_src0),
        .src1      (in_src1),
        .dst       (in_dst),
        .pend_src0 (pend_src0),
        .pend_src1 (pend_src1),
        .pend_dst  (pend_dst)
    );

    always_comb begin
        byp0 = 1'b0;
        byp1 = 1'b0;
`ifdef OPERAND_BYPASS_EN
        // The write retiring this cycle is the one the source waits on
        // (WAW stalls guarantee only one is outstanding), so forward it.
        byp0 = wb_wena && (wb_waddr == in_src0);
        byp1 = wb_wena && (wb_waddr == in_src1);
`endif
        hazard = in_valid && ((pend_src0 && !byp0) ||
                              (pend_src1 && !byp1) ||
                              (in_dst_wen && pend_dst));
        ready  = (!out_valid_q || out_ready) && !hazard;
        accept = in_valid && ready;
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_op0_d     = out_op0_q;
        out_op1_d     = out_op1_q;
        out_dst_d     = out_dst_q;
        out_dst_wen_d = out_dst_wen_q;
        stall_count_d = stall_count_q;

        if (accept) begin
            out_valid_d   = 1'b1;
            out_op0_d     = byp0 ? wb_wdata : rf_r0data;
            out_op1_d     = byp1 ? wb_wdata : rf_r1data;
            out_dst_d     = in_dst;
            out_dst_wen_d = in_dst_wen;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_valid && !ready && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_op0_q     <= '0;
            out_op1_q     <= '0;
            out_dst_q     <= '0;
            out_dst_wen_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_op0_q     <= out_op0_d;
            out_op1_q     <= out_op1_d;
            out_dst_q     <= out_dst_d;
            out_dst_wen_q <= out_dst_wen_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign in_ready    = ready;
    assign rf_r0addr   = in_src0;
    assign rf_r1addr   = in_src1;
    assign out_valid   = out_valid_q;
    assign out_op0     = out_op0_q;
    assign out_op1     = out_op1_q;
    assign out_dst     = out_dst_q;
    assign out_dst_wen = out_dst_wen_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

`ifdef OPERAND_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_src0, in_src1, in_dst;
    logic        in_dst_wen;
    logic [4:0]  rf_r0addr, rf_r1addr;
    logic [63:0] rf_r0data, rf_r1data;
    logic        wb_wena;
    logic [4:0]  wb_waddr;
    logic [63:0] wb_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_op0, out_op1;
    logic [4:0]  out_dst;
    logic        out_dst_wen;
    logic [15:0] stall_count;

    // Second instance with a 4-bit stall counter for the saturation check.
    logic        s_reset, s_in_valid, s_in_ready, s_in_dst_wen;
    logic [4:0]  s_in_src0, s_in_dst;
    logic [4:0]  s_rf_r0addr, s_rf_r1addr;
    logic        s_out_valid, s_out_dst_wen;
    logic [63:0] s_out_op0, s_out_op1;
    logic [4:0]  s_out_dst;
    logic [3:0]  s_stall_count;
    logic [63:0] zero64 = '0;
    logic [4:0]  zero5  = '0;
    logic        zero1  = 1'b0;
    logic        one1   = 1'b1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Register file attached to the stage: combinational read, clocked write.
    logic [63:0] rf_mem [32];
    assign rf_r0data = rf_mem[rf_r0addr];
    assign rf_r1data = rf_mem[rf_r1addr];
    always @(posedge clk) if (wb_wena) rf_mem[wb_waddr] <= wb_wdata;

    always #5 clk = ~clk;

    operand_fetch_stage u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_src0(in_src0), .in_src1(in_src1), .in_dst(in_dst), .in_dst_wen(in_dst_wen),
        .rf_r0addr(rf_r0addr), .rf_r1addr(rf_r1addr), .rf_r0data(rf_r0data), .rf_r1data(rf_r1data),
        .wb_wena(wb_wena), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_op0(out_op0), .out_op1(out_op1),
        .out_dst(out_dst), .out_dst_wen(out_dst_wen), .stall_count(stall_count)
    );

    operand_fetch_stage #(.CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_src0(s_in_src0), .in_src1(zero5), .in_dst(s_in_dst), .in_dst_wen(s_in_dst_wen),
        .rf_r0addr(s_rf_r0addr), .rf_r1addr(s_rf_r1addr), .rf_r0data(zero64), .rf_r1data(zero64),
        .wb_wena(zero1), .wb_waddr(zero5), .wb_wdata(zero64),
        .out_valid(s_out_valid), .out_ready(one1), .out_op0(s_out_op0), .out_op1(s_out_op1),
        .out_dst(s_out_dst), .out_dst_wen(s_out_dst_wen), .stall_count(s_stall_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; in_valid = 1'b0; wb_wena = 1'b0; out_ready = 1'b1;
        in_src0 = '0; in_src1 = '0; in_dst = '0; in_dst_wen = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; wb_wena = 1'b0; out_ready = 1'b1;
        in_src0 = 5'h03; in_src1 = 5'h04; in_dst = '0; in_dst_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0h want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0h want 1", in_ready); else pass_cnt++;
        chk_cnt++; if (stall_count !== 16'd0) $display("FAIL reset_stall_count got %0d want 0", stall_count); else pass_cnt++;
        chk_cnt++; if ({out_op0, out_op1, out_dst, out_dst_wen} !== '0) $display("FAIL reset_outputs got %0h/%0h/%0h/%0h want 0", out_op0, out_op1, out_dst, out_dst_wen); else pass_cnt++;
        chk_cnt++; if ({rf_r0addr, rf_r1addr} !== {5'h03, 5'h04}) $display("FAIL raddr_passthru got %0h/%0h want 3/4", rf_r0addr, rf_r1addr); else pass_cnt++;
        // Reset in the middle of operation drops the held output and pending bits.
        in_valid = 1'b1; in_src0 = '0; in_src1 = '0; in_dst = 5'h09; in_dst_wen = 1'b1; out_ready = 1'b0;
        tick();
        reset = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_src0 = 5'h09; in_dst_wen = 1'b0;
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid got %0h want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL midreset_pend_cleared got %0h want 1", in_ready); else pass_cnt++;
        in_valid = 1'b0;
    endtask

    task automatic test_read;
        do_reset();
        wb_wena = 1'b1; wb_waddr = 5'h10; wb_wdata = 64'ha5a5; tick();
        wb_waddr = 5'h1f; wb_wdata = 64'hf0f0; tick();
        wb_wena = 1'b0;
        in_valid = 1'b1; in_src0 = 5'h1f; in_src1 = 5'h10; in_dst = 5'h00; in_dst_wen = 1'b0;
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL read_in_ready got %0h want 1", in_ready); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL read_latency got %0h want 0", out_valid); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        chk_cnt++; if (out_valid !== 1'b1) $display("FAIL read_out_valid got %0h want 1", out_valid); else pass_cnt++;
        chk_cnt++; if (out_op0 !== 64'hf0f0) $display("FAIL read_op0 got %0h want f0f0", out_op0); else pass_cnt++;
        chk_cnt++; if (out_op1 !== 64'ha5a5) $display("FAIL read_op1 got %0h want a5a5", out_op1); else pass_cnt++;
        tick();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL read_drain got %0h want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_raw;
        do_reset();
        in_valid = 1'b1; in_src0 = '0; in_src1 = '0; in_dst = 5'h05; in_dst_wen = 1'b1;
        tick();
        in_src0 = 5'h05; in_dst = 5'h06;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_cnt++; if (in_ready !== 1'b0) $display("FAIL raw_hold_ready cyc %0d got %0h want 0", i, in_ready); else pass_cnt++;
            tick();
        end
        chk_cnt++; if (stall_count !== 16'd3) $display("FAIL raw_stall_hold got %0d want 3", stall_count); else pass_cnt++;
        wb_wena = 1'b1; wb_waddr = 5'h05; wb_wdata = 64'h1234;
        #1;
        chk_cnt++; if (in_ready !== BYPASS) $display("FAIL raw_wb_cycle_ready got %0h want %0h", in_ready, BYPASS); else pass_cnt++;
        tick();
        wb_wena = 1'b0;
        if (!BYPASS) begin
            #1;
            chk_cnt++; if (in_ready !== 1'b1) $display("FAIL raw_after_wb_ready got %0h want 1", in_ready); else pass_cnt++;
            tick();
        end
        in_valid = 1'b0;
        chk_cnt++; if (out_valid !== 1'b1 || out_dst !== 5'h06) $display("FAIL raw_accept got v=%0h dst=%0h want v=1 dst=6", out_valid, out_dst); else pass_cnt++;
        chk_cnt++; if (out_op0 !== 64'h1234) $display("FAIL raw_op0 got %0h want 1234", out_op0); else pass_cnt++;
        chk_cnt++; if (stall_count !== (BYPASS ? 16'd3 : 16'd4)) $display("FAIL raw_stall_final got %0d want %0d", stall_count, BYPASS ? 3 : 4); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_src0 = 5'h10; in_src1 = 5'h1f; in_dst = 5'h00; in_dst_wen = 1'b0;
        tick();
        in_src0 = 5'h1f; in_src1 = 5'h10; in_dst = 5'h02; in_dst_wen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready cyc %0d got %0h want 0", i, in_ready); else pass_cnt++;
            chk_cnt++; if ({out_valid, out_op0, out_op1, out_dst, out_dst_wen} !== {1'b1, 64'ha5a5, 64'hf0f0, 5'h00, 1'b0})
                $display("FAIL bp_stable cyc %0d got v=%0h op0=%0h op1=%0h dst=%0h want v=1 op0=a5a5 op1=f0f0 dst=0", i, out_valid, out_op0, out_op1, out_dst); else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %0h want 1", in_ready); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        chk_cnt++; if ({out_valid, out_op0, out_dst, out_dst_wen} !== {1'b1, 64'hf0f0, 5'h02, 1'b1})
            $display("FAIL bp_next got v=%0h op0=%0h dst=%0h wen=%0h want 1/f0f0/2/1", out_valid, out_op0, out_dst, out_dst_wen); else pass_cnt++;
        chk_cnt++; if (stall_count !== 16'd4) $display("FAIL bp_stall_count got %0d want 4", stall_count); else pass_cnt++;
    endtask

    task automatic test_same_cycle;
        do_reset();
        // Writeback clears 0x07 in the cycle an instruction setting 0x07 is accepted.
        in_valid = 1'b1; in_src0 = 5'h01; in_src1 = 5'h02; in_dst = 5'h07; in_dst_wen = 1'b1;
        wb_wena = 1'b1; wb_waddr = 5'h07; wb_wdata = 64'h77;
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL setclr_accept got %0h want 1", in_ready); else pass_cnt++;
        tick();
        wb_wena = 1'b0;
        in_src0 = 5'h07; in_src1 = 5'h01; in_dst = 5'h08;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_cnt++; if (in_ready !== 1'b0) $display("FAIL setclr_stall cyc %0d got %0h want 0", i, in_ready); else pass_cnt++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_saturate;
        s_reset = 1'b1; s_in_valid = 1'b0; s_in_src0 = '0; s_in_dst = 5'h03; s_in_dst_wen = 1'b1;
        tick();
        s_reset = 1'b0; s_in_valid = 1'b1;
        tick();
        s_in_src0 = 5'h03; s_in_dst_wen = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk_cnt++; if (s_stall_count !== 4'd15) $display("FAIL sat_count got %0d want 15", s_stall_count); else pass_cnt++;
        chk_cnt++; if (s_in_ready !== 1'b0) $display("FAIL sat_ready got %0h want 0", s_in_ready); else pass_cnt++;
        s_in_valid = 1'b0;
    endtask

    // Reference model: architectural register values, a set of registers with
    // an outstanding write, and the expected content of the output register.
    logic [63:0] mdl_regs [32];
    logic [4:0]  pend_list [$];

    function automatic bit is_pending(input logic [4:0] r);
        foreach (pend_list[i]) if (pend_list[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_random;
        bit          e_ov, hit0, hit1, haz, er, acc;
        logic [63:0] e_op0, e_op1;
        logic [4:0]  e_dst;
        logic        e_wen;
        int          e_stall;
        int          k;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_dst_wen = 1'b0;
        for (int r = 0; r < 32; r++) begin
            wb_wena = 1'b1; wb_waddr = 5'(r); wb_wdata = {$urandom, $urandom};
            mdl_regs[r] = wb_wdata;
            tick();
        end
        wb_wena = 1'b0;
        tick();
        reset = 1'b0;
        pend_list.delete();
        e_ov = 1'b0; e_op0 = '0; e_op1 = '0; e_dst = '0; e_wen = 1'b0; e_stall = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_src0    = 5'($urandom_range(0, 7));
            in_src1    = 5'($urandom_range(0, 7));
            in_dst     = 5'($urandom_range(0, 7));
            in_dst_wen = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 3) != 0);
            if (pend_list.size() > 0 && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, pend_list.size() - 1);
                wb_wena = 1'b1; wb_waddr = pend_list[k]; wb_wdata = {$urandom, $urandom};
            end else begin
                wb_wena = 1'b0;
            end
            #1;
            hit0 = BYPASS && wb_wena && (wb_waddr == in_src0);
            hit1 = BYPASS && wb_wena && (wb_waddr == in_src1);
            haz  = in_valid && ((is_pending(in_src0) && !hit0) || (is_pending(in_src1) && !hit1) ||
                                (in_dst_wen && is_pending(in_dst)));
            er   = (!e_ov || out_ready) && !haz;
            acc  = in_valid && er;
            chk_cnt++; if (in_ready !== er) $display("FAIL rnd_in_ready cyc %0d got %0h want %0h", cyc, in_ready, er); else pass_cnt++;
            if (acc) begin
                e_op0 = hit0 ? wb_wdata : mdl_regs[in_src0];
                e_op1 = hit1 ? wb_wdata : mdl_regs[in_src1];
                e_dst = in_dst; e_wen = in_dst_wen; e_ov = 1'b1;
            end else if (out_ready) begin
                e_ov = 1'b0;
            end
            if (in_valid && !er && e_stall < 65535) e_stall++;
            if (wb_wena) begin
                mdl_regs[wb_waddr] = wb_wdata;
                foreach (pend_list[i]) if (pend_list[i] == wb_waddr) begin pend_list.delete(i); break; end
            end
            if (acc && in_dst_wen) pend_list.push_back(in_dst);
            tick();
            chk_cnt++; if (out_valid !== e_ov) $display("FAIL rnd_out_valid cyc %0d got %0h want %0h", cyc, out_valid, e_ov); else pass_cnt++;
            if (e_ov) begin
                chk_cnt++; if ({out_op0, out_op1} !== {e_op0, e_op1}) $display("FAIL rnd_ops cyc %0d got %0h/%0h want %0h/%0h", cyc, out_op0, out_op1, e_op0, e_op1); else pass_cnt++;
                chk_cnt++; if ({out_dst, out_dst_wen} !== {e_dst, e_wen}) $display("FAIL rnd_dst cyc %0d got %0h/%0h want %0h/%0h", cyc, out_dst, out_dst_wen, e_dst, e_wen); else pass_cnt++;
            end
            chk_cnt++; if (stall_count !== 16'(e_stall)) $display("FAIL rnd_stall cyc %0d got %0d want %0d", cyc, stall_count, e_stall); else pass_cnt++;
        end
        in_valid = 1'b0; wb_wena = 1'b0;
    endtask

    initial begin
        s_reset = 1'b1; s_in_valid = 1'b0; s_in_src0 = '0; s_in_dst = '0; s_in_dst_wen = 1'b0;
        test_reset();
        test_read();
        test_raw();
        test_backpressure();
        test_same_cycle();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
